// File: rtl/pwm_pkg.sv
// ============================================================================
// Module   : pwm_pkg
// Purpose  : Shared types and default sizing for the PWM capture block.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package pwm_pkg;

    // Default sizing, used as parameter defaults by the capture block
    localparam int c_CNT_W    = 32;
    localparam int c_TIMEOUT  = 65535;
    localparam int c_FILT_LEN = 3;

    // Measurement FSM: waiting for a first rise, inside the high phase, inside the low phase
    typedef enum logic [1:0] {
        ARM  = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } pwm_state_t;

endpackage : pwm_pkg

`default_nettype wire

// File: rtl/pwm_capture_if.sv
// ============================================================================
// Module   : pwm_capture_if
// Purpose  : Control / PWM input and measurement result bundle of pwm_capture.
//            slave  = capture block side, master = consumer / stimulus side.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface pwm_capture_if
    import pwm_pkg::*;
#(
    parameter int CNT_W = c_CNT_W
);
    logic             enable;
    logic             pwm_in;
    logic [CNT_W-1:0] high_time;
    logic [CNT_W-1:0] period;
    logic             meas_valid;
    logic             timeout;
    logic             stuck_level;

    modport master (
        output enable, pwm_in,
        input  high_time, period, meas_valid, timeout, stuck_level
    );

    modport slave (
        input  enable, pwm_in,
        output high_time, period, meas_valid, timeout, stuck_level
    );

endinterface : pwm_capture_if

`default_nettype wire

// File: rtl/pwm_sync_edge.sv
// ============================================================================
// Module   : pwm_sync_edge
// Purpose  : 2-FF synchroniser for the asynchronous PWM line, optional deglitch
//            filter, registered rise/fall pulses and the synced line level.
//            Optional feature macro: PWM_CAP_DEGLITCH_EN (enables the filter).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pwm_sync_edge
    import pwm_pkg::*;
`ifdef PWM_CAP_DEGLITCH_EN
#(
    parameter int FILT_LEN = c_FILT_LEN
)
`endif
(
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic i_pwm,
    output logic      o_rise,
    output logic      o_fall,
    output logic      o_level
);

    logic r_sync1;
    logic r_sync2;
    logic r_level;
    logic r_rise;
    logic r_fall;
    logic w_level;

    // Two-stage synchroniser bringing the pin into the clk domain
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_pwm;
            r_sync2 <= r_sync1;
        end
    end

`ifdef PWM_CAP_DEGLITCH_EN
    localparam int c_FCNT_W = $clog2(FILT_LEN + 1);

    logic                r_filt;
    logic [c_FCNT_W-1:0] r_fcnt;

    // Filtered level follows the synced line only after FILT_LEN equal disagreeing samples
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_filt <= 1'b0;
            r_fcnt <= '0;
        end else if (r_sync2 == r_filt) begin
            r_fcnt <= '0;
        end else if (r_fcnt == c_FCNT_W'(FILT_LEN - 1)) begin
            r_filt <= r_sync2;
            r_fcnt <= '0;
        end else begin
            r_fcnt <= r_fcnt + 1'b1;
        end
    end

    assign w_level = r_filt;
`else
    assign w_level = r_sync2;
`endif

    // Edge detector: one-cycle pulses registered together with the level they describe
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_level <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_level <= w_level;
            r_rise  <= w_level & ~r_level;
            r_fall  <= ~w_level & r_level;
        end
    end

    assign o_rise  = r_rise;
    assign o_fall  = r_fall;
    assign o_level = r_level;

endmodule : pwm_sync_edge

`default_nettype wire

// File: rtl/pwm_capture.sv
// ============================================================================
// Module   : pwm_capture
// Purpose  : Measures high time and period of an asynchronous PWM line in clk
//            cycles, one result per PWM period, and flags a stuck line.
//            Optional feature macro: PWM_CAP_DEGLITCH_EN (input deglitch filter).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pwm_capture
    import pwm_pkg::*;
#(
    parameter int CNT_W   = c_CNT_W,
    parameter int TIMEOUT = c_TIMEOUT
`ifdef PWM_CAP_DEGLITCH_EN
    ,
    parameter int FILT_LEN = c_FILT_LEN
`endif
)
(
    input wire logic       clk,
    input wire logic       rst,
    pwm_capture_if.slave   bus
);

    localparam logic [CNT_W-1:0] c_TMO    = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] c_TMO_M1 = CNT_W'(TIMEOUT - 1);

    logic w_rise;
    logic w_fall;
    logic w_level;
    logic w_edge;

    pwm_sync_edge
`ifdef PWM_CAP_DEGLITCH_EN
    #(
        .FILT_LEN (FILT_LEN)
    )
`endif
    u_sync_edge (
        .clk     (clk),
        .rst     (rst),
        .i_pwm   (bus.pwm_in),
        .o_rise  (w_rise),
        .o_fall  (w_fall),
        .o_level (w_level)
    );

    assign w_edge = w_rise | w_fall;

    pwm_state_t       r_state,      w_state_nxt;
    logic [CNT_W-1:0] r_cnt,        w_cnt_nxt;
    logic [CNT_W-1:0] r_edge_cnt,   w_edge_cnt_nxt;
    logic [CNT_W-1:0] r_hi_lat,     w_hi_lat_nxt;
    logic [CNT_W-1:0] r_high_time,  w_high_time_nxt;
    logic [CNT_W-1:0] r_period,     w_period_nxt;
    logic             r_meas_valid, w_meas_valid_nxt;
    logic             r_timeout,    w_timeout_nxt;
    logic             r_stuck,      w_stuck_nxt;
    logic [CNT_W-1:0] w_cnt_inc;
    logic [CNT_W-1:0] w_edge_inc;

    // State, counter and result registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= ARM;
            r_cnt        <= '0;
            r_edge_cnt   <= '0;
            r_hi_lat     <= '0;
            r_high_time  <= '0;
            r_period     <= '0;
            r_meas_valid <= 1'b0;
            r_timeout    <= 1'b0;
            r_stuck      <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_edge_cnt   <= w_edge_cnt_nxt;
            r_hi_lat     <= w_hi_lat_nxt;
            r_high_time  <= w_high_time_nxt;
            r_period     <= w_period_nxt;
            r_meas_valid <= w_meas_valid_nxt;
            r_timeout    <= w_timeout_nxt;
            r_stuck      <= w_stuck_nxt;
        end
    end

    // Next-state logic: measurement FSM, saturating counters and stuck-line watchdog
    always_comb begin
        w_cnt_inc        = (r_cnt == c_TMO) ? r_cnt : r_cnt + 1'b1;
        w_edge_inc       = (r_edge_cnt == c_TMO) ? r_edge_cnt : r_edge_cnt + 1'b1;
        w_state_nxt      = r_state;
        w_cnt_nxt        = r_cnt;
        w_edge_cnt_nxt   = r_edge_cnt;
        w_hi_lat_nxt     = r_hi_lat;
        w_high_time_nxt  = r_high_time;
        w_period_nxt     = r_period;
        w_meas_valid_nxt = 1'b0;
        w_timeout_nxt    = r_timeout;
        w_stuck_nxt      = r_stuck;

        if (!bus.enable) begin
            // Results and timeout flag hold; a fresh rise is needed after re-enable
            w_state_nxt    = ARM;
            w_cnt_nxt      = '0;
            w_edge_cnt_nxt = '0;
        end else begin
            w_edge_cnt_nxt = w_edge ? '0 : w_edge_inc;

            case (r_state)
                ARM: begin
                    w_cnt_nxt = '0;
                    if (w_rise) begin
                        w_state_nxt = HIGH;
                        w_cnt_nxt   = CNT_W'(1);
                    end
                end
                HIGH: begin
                    w_cnt_nxt = w_cnt_inc;
                    if (w_fall) begin
                        w_state_nxt  = LOW;
                        w_hi_lat_nxt = r_cnt;
                    end
                end
                LOW: begin
                    w_cnt_nxt = w_cnt_inc;
                    if (w_rise) begin
                        // Closing rise also opens the next period, so no cycle is lost
                        w_state_nxt      = HIGH;
                        w_period_nxt     = r_cnt;
                        w_high_time_nxt  = r_hi_lat;
                        w_meas_valid_nxt = 1'b1;
                        w_timeout_nxt    = 1'b0;
                        w_cnt_nxt        = CNT_W'(1);
                    end
                end
                default: begin
                    w_state_nxt = ARM;
                    w_cnt_nxt   = '0;
                end
            endcase

            // Fires once when the edge counter reaches TIMEOUT; an edge this cycle wins
            if (!w_edge && (r_edge_cnt == c_TMO_M1)) begin
                w_timeout_nxt = 1'b1;
                w_stuck_nxt   = w_level;
                w_state_nxt   = ARM;
                w_cnt_nxt     = '0;
            end
        end
    end

    assign bus.high_time   = r_high_time;
    assign bus.period      = r_period;
    assign bus.meas_valid  = r_meas_valid;
    assign bus.timeout     = r_timeout;
    assign bus.stuck_level = r_stuck;

endmodule : pwm_capture

`default_nettype wire
